// File: rtl/cam_threshold_capture.sv
// Camera capture and binarisation: decodes VSYNC/HREF YUYV bytes, thresholds luma
// and writes one bit per pixel at a strictly sequential raster address.
module cam_threshold_capture #(
    parameter int H_PIXELS = 320,
    parameter int V_LINES  = 240
) (
    input  logic        cam_pclk,
    input  logic        reset,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic [7:0]  thresh,
    output logic        wr_en,
    output logic [16:0] wr_addr,
    output logic        wr_data,
    output logic        frame_done,
    output logic        frame_err
);

    localparam int COL_W  = $clog2(H_PIXELS + 1);
    localparam int LINE_W = $clog2(V_LINES + 2);

    localparam logic [COL_W-1:0]  COL_MAX      = COL_W'(H_PIXELS);
    localparam logic [COL_W-1:0]  COL_ONE      = COL_W'(1);
    localparam logic [LINE_W-1:0] LINE_MAX     = LINE_W'(V_LINES);
    localparam logic [LINE_W-1:0] LINE_SAT     = LINE_W'(V_LINES + 1);
    localparam logic [LINE_W-1:0] LINE_ONE     = LINE_W'(1);
    localparam logic [16:0]       FRAME_PIXELS = 17'(H_PIXELS * V_LINES);

    typedef enum logic [1:0] {
        SYNC,
        VBLANK,
        ACTIVE
    } state_t;

    state_t state;
    state_t state_next;

    logic              href_q;
    logic              phase;
    logic              bad;
    logic [7:0]        y_q;
    logic [7:0]        thresh_q;
    logic [COL_W-1:0]  col;
    logic [LINE_W-1:0] line;
    logic [16:0]       pix_addr;

    logic href_rise;
    logic href_fall;
    logic byte_phase;
    logic frame_start;
    logic frame_end;
    logic take_byte;
    logic line_end;
    logic in_range;
    logic frame_ok;

    assign href_rise  = cam_href & ~href_q;
    assign href_fall  = ~cam_href & href_q;
    assign byte_phase = href_rise ? 1'b0 : phase;
    assign in_range   = (col < COL_MAX) && (line < LINE_MAX);
    assign frame_ok   = (line == LINE_MAX) && !bad && (pix_addr == FRAME_PIXELS);

    always_ff @(posedge cam_pclk or posedge reset) begin
        if (reset) begin
            state <= SYNC;
        end else begin
            state <= state_next;
        end
    end

    // A rising vsync in ACTIVE takes priority over any byte sampled on the same edge.
    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        take_byte   = 1'b0;
        line_end    = 1'b0;
        case (state)
            SYNC: begin
                if (cam_vsync) begin
                    state_next = VBLANK;
                end
            end
            VBLANK: begin
                if (!cam_vsync) begin
                    state_next  = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (cam_vsync) begin
                    state_next = VBLANK;
                    frame_end  = 1'b1;
                end else begin
                    take_byte = cam_href;
                    line_end  = href_fall;
                end
            end
            default: begin
                state_next = SYNC;
            end
        endcase
    end

    always_ff @(posedge cam_pclk or posedge reset) begin
        if (reset) begin
            href_q     <= 1'b0;
            phase      <= 1'b0;
            bad        <= 1'b0;
            y_q        <= 8'd0;
            thresh_q   <= 8'd0;
            col        <= '0;
            line       <= '0;
            pix_addr   <= 17'd0;
            wr_en      <= 1'b0;
            wr_addr    <= 17'd0;
            wr_data    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            href_q     <= cam_href;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            if (frame_start) begin
                col      <= '0;
                line     <= '0;
                pix_addr <= 17'd0;
                bad      <= 1'b0;
                phase    <= 1'b0;
                thresh_q <= thresh;
            end

            // Out-of-range pixels are dropped so the address run never exceeds one frame.
            if (take_byte) begin
                phase <= ~byte_phase;
                if (!byte_phase) begin
                    y_q <= cam_data;
                end else if (in_range) begin
                    wr_en    <= 1'b1;
                    wr_addr  <= pix_addr;
                    wr_data  <= (y_q >= thresh_q);
                    pix_addr <= pix_addr + 17'd1;
                    col      <= col + COL_ONE;
                end else begin
                    bad <= 1'b1;
                end
            end

            // A still-set phase at end of line means a luma byte lost its chroma partner.
            if (line_end) begin
                if ((col != COL_MAX) || phase) begin
                    bad <= 1'b1;
                end
                col   <= '0;
                phase <= 1'b0;
                if (line != LINE_SAT) begin
                    line <= line + LINE_ONE;
                end
            end

            if (frame_end) begin
                frame_done <= frame_ok;
                frame_err  <= ~frame_ok;
            end
        end
    end

endmodule

// File: tb/tb_cam_threshold_capture.sv
// Directed bench for cam_threshold_capture using a reduced 8x6 frame geometry.
module tb_cam_threshold_capture;

    localparam int H = 8;
    localparam int V = 6;

    logic        clk;
    logic        reset;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic [7:0]  thresh;
    logic        wr_en;
    logic [16:0] wr_addr;
    logic        wr_data;
    logic        frame_done;
    logic        frame_err;

    typedef struct {
        logic [16:0] addr;
        logic        data;
    } wr_t;

    wr_t wr_log[$];
    int  done_count = 0;
    int  err_count  = 0;
    int  both_count = 0;
    int  done_snap  = 0;
    int  err_snap   = 0;
    int  checks     = 0;
    int  errors     = 0;

    int n, order_bad, ones, max_addr, parity_bad;

    cam_threshold_capture #(
        .H_PIXELS(H),
        .V_LINES (V)
    ) dut (
        .cam_pclk  (clk),
        .reset     (reset),
        .cam_vsync (vsync),
        .cam_href  (href),
        .cam_data  (data),
        .thresh    (thresh),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_done(frame_done),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records every write and end-of-frame pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en === 1'b1) wr_log.push_back('{wr_addr, wr_data});
        if (frame_done === 1'b1) done_count++;
        if (frame_err === 1'b1) err_count++;
        if (frame_done === 1'b1 && frame_err === 1'b1) both_count++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic clearLog();
        wr_log.delete();
        done_snap = done_count;
        err_snap  = err_count;
    endtask

    task automatic startFrame();
        vsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic endFrame();
        vsync = 1'b1;
        href  = 1'b0;
        repeat (4) tick();
    endtask

    task automatic applyStimulus(input int npix, input logic [7:0] y_even, input logic [7:0] y_odd);
        for (int c = 0; c < npix; c++) begin
            href = 1'b1;
            data = (c % 2 == 0) ? y_even : y_odd;
            tick();
            data = 8'h5A;
            tick();
        end
        href = 1'b0;
        data = 8'h00;
        repeat (3) tick();
    endtask

    task automatic analyzeLog();
        n = wr_log.size();
        order_bad = 0;
        ones = 0;
        max_addr = -1;
        parity_bad = 0;
        foreach (wr_log[i]) begin
            if (int'(wr_log[i].addr) != i) order_bad++;
            if (wr_log[i].data === 1'b1) ones++;
            if (int'(wr_log[i].addr) > max_addr) max_addr = int'(wr_log[i].addr);
            if (wr_log[i].data !== !wr_log[i].addr[0]) parity_bad++;
        end
    endtask

    initial begin
        reset  = 1'b1;
        vsync  = 1'b1;
        href   = 1'b0;
        data   = 8'h00;
        thresh = 8'h7F;
        repeat (3) tick();
        checkOutput("reset_wr_en", 32'(wr_en), 0);
        checkOutput("reset_wr_addr", 32'(wr_addr), 0);
        checkOutput("reset_wr_data", 32'(wr_data), 0);
        checkOutput("reset_done", 32'(frame_done), 0);
        checkOutput("reset_err", 32'(frame_err), 0);
        reset = 1'b0;
        repeat (2) tick();

        $display("[TB] frame 1: all Y=0x80, thresh 0x7F");
        clearLog();
        startFrame();
        for (int l = 0; l < V; l++) applyStimulus(H, 8'h80, 8'h80);
        endFrame();
        analyzeLog();
        checkOutput("f1_writes", n, H * V);
        checkOutput("f1_order", order_bad, 0);
        checkOutput("f1_ones", ones, H * V);
        checkOutput("f1_done", done_count - done_snap, 1);
        checkOutput("f1_err", err_count - err_snap, 0);

        $display("[TB] frame 2: threshold boundary, thresh change mid-frame");
        thresh = 8'h40;
        clearLog();
        startFrame();
        for (int l = 0; l < V; l++) begin
            if (l == 2) thresh = 8'hFF;
            applyStimulus(H, 8'h40, 8'h3F);
        end
        endFrame();
        analyzeLog();
        checkOutput("f2_writes", n, H * V);
        checkOutput("f2_ones", ones, H * V / 2);
        checkOutput("f2_parity", parity_bad, 0);
        checkOutput("f2_done", done_count - done_snap, 1);

        $display("[TB] frame 3: new threshold 0xFF now in effect");
        clearLog();
        startFrame();
        for (int l = 0; l < V; l++) applyStimulus(H, 8'h40, 8'h40);
        endFrame();
        analyzeLog();
        checkOutput("f3_writes", n, H * V);
        checkOutput("f3_ones", ones, 0);
        checkOutput("f3_done", done_count - done_snap, 1);

        $display("[TB] frame 4: short line");
        thresh = 8'h7F;
        clearLog();
        startFrame();
        for (int l = 0; l < V; l++) applyStimulus((l == 3) ? H - 1 : H, 8'h80, 8'h80);
        endFrame();
        analyzeLog();
        checkOutput("f4_writes", n, H * V - 1);
        checkOutput("f4_order", order_bad, 0);
        checkOutput("f4_err", err_count - err_snap, 1);
        checkOutput("f4_done", done_count - done_snap, 0);

        $display("[TB] frame 5: clean frame after error");
        clearLog();
        startFrame();
        for (int l = 0; l < V; l++) applyStimulus(H, 8'h80, 8'h80);
        endFrame();
        analyzeLog();
        checkOutput("f5_writes", n, H * V);
        checkOutput("f5_order", order_bad, 0);
        checkOutput("f5_done", done_count - done_snap, 1);
        checkOutput("f5_err", err_count - err_snap, 0);

        $display("[TB] frame 6: long line");
        clearLog();
        startFrame();
        for (int l = 0; l < V; l++) applyStimulus((l == 1) ? H + 1 : H, 8'h80, 8'h80);
        endFrame();
        analyzeLog();
        checkOutput("f6_writes", n, H * V);
        checkOutput("f6_max_addr", max_addr, H * V - 1);
        checkOutput("f6_err", err_count - err_snap, 1);
        checkOutput("f6_done", done_count - done_snap, 0);

        $display("[TB] frame 7: extra line");
        clearLog();
        startFrame();
        for (int l = 0; l < V + 1; l++) applyStimulus(H, 8'h80, 8'h80);
        endFrame();
        analyzeLog();
        checkOutput("f7_writes", n, H * V);
        checkOutput("f7_max_addr", max_addr, H * V - 1);
        checkOutput("f7_err", err_count - err_snap, 1);
        checkOutput("f7_done", done_count - done_snap, 0);

        $display("[TB] frame 8: reset mid-frame");
        clearLog();
        startFrame();
        for (int l = 0; l < 2; l++) applyStimulus(H, 8'h80, 8'h80);
        href = 1'b1;
        for (int c = 0; c < 3; c++) begin
            data = 8'h80;
            tick();
            data = 8'h5A;
            if (c < 2) tick();
        end
        @(posedge clk);
        #2;
        checkOutput("pre_reset_wr_en", 32'(wr_en), 1);
        checkOutput("pre_reset_wr_addr", 32'(wr_addr), 2 * H + 2);
        reset = 1'b1;
        #1;
        checkOutput("mid_reset_wr_en", 32'(wr_en), 0);
        checkOutput("mid_reset_wr_addr", 32'(wr_addr), 0);
        checkOutput("mid_reset_wr_data", 32'(wr_data), 0);
        tick();
        data = 8'h80;
        tick();
        data = 8'h5A;
        tick();
        reset = 1'b0;
        clearLog();
        for (int c = 4; c < H; c++) begin
            data = 8'h80;
            tick();
            data = 8'h5A;
            tick();
        end
        href = 1'b0;
        repeat (3) tick();
        for (int l = 3; l < V; l++) applyStimulus(H, 8'h80, 8'h80);
        endFrame();
        analyzeLog();
        checkOutput("aborted_writes", n, 0);
        checkOutput("aborted_done", done_count - done_snap, 0);
        checkOutput("aborted_err", err_count - err_snap, 0);

        clearLog();
        startFrame();
        for (int l = 0; l < V; l++) applyStimulus(H, 8'h80, 8'h80);
        endFrame();
        analyzeLog();
        checkOutput("f9_writes", n, H * V);
        checkOutput("f9_order", order_bad, 0);
        checkOutput("f9_done", done_count - done_snap, 1);
        checkOutput("f9_err", err_count - err_snap, 0);
        checkOutput("done_err_overlap", both_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
